sparse_pe: RTL and testbench
============================

# sparse_pe

Parametrised sparse-convolution processing element, successor to the fixed-size PE. Accepts one compressed input-activation (IA) vector and one compressed weight vector per job. Intersects their sorted channel-index lists, multiplies matched pairs and accumulates the products into an on-block output buffer addressed per weight. Adds multi-pass accumulation, saturation with a sticky flag, and a ready/valid readout stream, none of which the earlier PE has.

## Interface
- IA_DW, 16: IA data width (signed)
- W_DW, 16: weight data width (signed)
- ACC_W, 36: accumulator width (signed), must be at least IA_DW+W_DW
- C_W, 8: channel-index width
- IA_LEN, 32: maximum IA nonzeros per job
- W_LEN, 32: maximum weight nonzeros per job
- OUT_DEPTH, 96: output-buffer entries; AW = $clog2(OUT_DEPTH)
- i_clk  in  1  clock; sole clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  job start; sampled only in IDLE
- i_acc_clear  in  1  sampled with i_start; 1 zeroes the whole buffer before the job
- i_ia_data  in  IA_LEN×IA_DW  IA values
- i_ia_c  in  IA_LEN×C_W  IA channel indices, strictly ascending
- i_ia_len  in  $clog2(IA_LEN)+1  valid IA entries, 0..IA_LEN
- i_w_data  in  W_LEN×W_DW  weight values
- i_w_c  in  W_LEN×C_W  weight channel indices, non-decreasing
- i_w_addr  in  W_LEN×AW  output-buffer address per weight
- i_w_len  in  $clog2(W_LEN)+1  valid weight entries, 0..W_LEN
- i_rd_start  in  1  begin readout; sampled only in IDLE
- i_rd_ready  in  1  readout consumer ready
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse when the job's last accumulate has retired
- o_sat  out  1  sticky: some accumulate saturated since the last accepted i_start
- o_rd_valid  out  1  readout data valid
- o_rd_data  out  ACC_W  accumulator value
- o_rd_addr  out  AW  address of o_rd_data
- o_rd_last  out  1  high with the entry at OUT_DEPTH-1

## Operation
- States: IDLE, MATCH, DRAIN, READ.
- IDLE + i_start:
  - latch both bundles and lengths;
  - p=q=0; clear o_sat;
  - if i_acc_clear, zero all entries;
  - go to MATCH.
- i_start has priority over i_rd_start if both are high.
- IDLE + i_rd_start: rd_ptr=0, go to READ.
- MATCH, one comparison per cycle, comparing ia_c[p] with w_c[q]:
  - equal: issue a MAC of ia_data[p]×w_data[q] to w_addr[q]; q++. p is held, so repeated weight channels each match the same IA entry.
  - ia_c[p] < w_c[q]: p++.
  - ia_c[p] > w_c[q]: q++.
  - When p==ia_len or q==w_len, go to DRAIN. A zero length exits on the first MATCH cycle with no MAC.
- MAC pipeline:
  - P1 registers the full-width signed product (IA_DW+W_DW).
  - P2 sign-extends the product to ACC_W and does a saturating add into acc[addr]: clamp to ±(2^(ACC_W-1)-1 / -2^(ACC_W-1)), then set o_sat.
  - Back-to-back MACs to the same address must forward the P2 result, so every product is counted exactly once.
- DRAIN: 2 cycles, then IDLE with o_done=1 in the first IDLE cycle.
- READ:
  - o_rd_valid=1; o_rd_data=acc[rd_ptr]; o_rd_addr=rd_ptr.
  - Advance on valid&ready.
  - After the handshake with rd_ptr=OUT_DEPTH-1, return to IDLE.
  - Data must hold stable while i_rd_ready=0.
- Without i_acc_clear, the buffer persists across jobs, giving multi-pass accumulation over channel tiles.
- i_start and i_rd_start outside IDLE are ignored.
- Entries at or beyond i_ia_len / i_w_len are never read.

## Timing
- Reset (async, i_rst=1): state=IDLE, all accumulators=0, p=q=rd_ptr=0, pipeline valids=0. Outputs: o_busy=0, o_done=0, o_sat=0, o_rd_valid=0, o_rd_data=0, o_rd_addr=0, o_rd_last=0.
- Reset mid-job or mid-readout aborts; no o_done is produced.
- Start accepted at edge T: o_busy=1 from T+1; the first comparison happens in cycle T+1.
- A job with N MATCH cycles (N ≤ ia_len+w_len, minimum 1) has o_done at T+N+3.
- The last MAC retires into the buffer before o_done rises. A readout started on the o_done cycle sees the final values.
- Readout: first o_rd_valid in the cycle after i_rd_start is accepted. With i_rd_ready held high, the stream is OUT_DEPTH cycles.

## Structure
- Package sparse_pe_pkg holds:
  - the state enum;
  - the saturating-add function, parametrised by ACC_W;
  - default parameter constants;
  - a localparam AW helper.
- One sub-module, sparse_pe_acc_buf: OUT_DEPTH×ACC_W register array with clear-all, 2-stage multiply/saturating read-modify-write, same-address forwarding, and an asynchronous read port for readout.
- Top level holds the FSM, the intersect pointers and the readout handshake.

## Test plan
- IA c={1,3,5}, data={2,3,4}; W c={3,5}, data={10,-2}, addr={0,1}; clear → acc[0]=30, acc[1]=-8; o_done at T+4+3 (N = 4 MATCH cycles).
- Same job twice, the second run with i_acc_clear=0 → acc[0]=60, acc[1]=-16.
- W c={2,2}, addr={5,5}, data={3,4}; IA c={2}, data={7} → back-to-back same-address MACs give acc[5]=49 (forwarding check).
- ACC_W=IA_DW+W_DW=32; accumulate 0x7FFF×0x7FFF three times to one address → acc saturates at 0x7FFFFFFF and o_sat=1; a new i_start clears o_sat.
- i_ia_len=0 → no buffer change, o_done at T+4; a readout streams OUT_DEPTH entries with i_rd_ready toggling every cycle; data is stable while stalled; o_rd_last only at address OUT_DEPTH-1.
- Assert i_rst mid-MATCH → all outputs 0 next cycle, no o_done; the buffer reads back all zeros.

Source files
------------

// File: rtl/sparse_pe_pkg.sv
// Shared types, default sizes and the saturating adder for the sparse PE.
package sparse_pe_pkg;
    localparam int DEF_IA_DW     = 16;
    localparam int DEF_W_DW      = 16;
    localparam int DEF_ACC_W     = 36;
    localparam int DEF_C_W       = 8;
    localparam int DEF_IA_LEN    = 32;
    localparam int DEF_W_LEN     = 32;
    localparam int DEF_OUT_DEPTH = 96;
    localparam int SAT_W         = 64;

    typedef enum logic [1:0] {ST_IDLE, ST_MATCH, ST_DRAIN, ST_READ} state_t;

    typedef struct packed {
        logic             sat;
        logic [SAT_W-1:0] sum;
    } sat_res_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Operands arrive sign-extended from acc_w bits; the sum is clamped to the acc_w signed range.
    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                         input logic signed [SAT_W-1:0] b,
                                         input int acc_w);
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] maxv;
        logic signed [SAT_W-1:0] minv;
        sat_res_t r;
        s     = a + b;
        maxv  = $signed((SAT_W'(1) << (acc_w - 1)) - SAT_W'(1));
        minv  = ~maxv;
        r.sat = (s > maxv) || (s < minv);
        r.sum = (s > maxv) ? maxv : ((s < minv) ? minv : s);
        return r;
    endfunction
endpackage

// File: rtl/sparse_pe_acc_buf.sv
// Output accumulator buffer: 2-stage multiply / saturating read-modify-write with
// same-address forwarding, clear-all, and an asynchronous readout port.
module sparse_pe_acc_buf
    import sparse_pe_pkg::*;
#(
    parameter int IA_DW     = DEF_IA_DW,
    parameter int W_DW      = DEF_W_DW,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH,
    parameter int AW        = addr_w(DEF_OUT_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_mac_valid,
    input  logic [AW-1:0]    i_mac_addr,
    input  logic [IA_DW-1:0] i_mac_a,
    input  logic [W_DW-1:0]  i_mac_b,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [ACC_W-1:0] o_rd_data,
    output logic             o_sat
);
    localparam int PW = IA_DW + W_DW;

    logic [ACC_W-1:0] r_acc [OUT_DEPTH];
    logic             r_p1_valid;
    logic [AW-1:0]    r_p1_addr;
    logic [PW-1:0]    r_p1_prod;
    logic [ACC_W-1:0] r_p1_old;
    logic [PW-1:0]    w_prod;
    logic [ACC_W-1:0] w_old;
    logic [ACC_W-1:0] w_p2_sum;
    sat_res_t         w_res;

    assign w_prod = PW'($signed(i_mac_a)) * PW'($signed(i_mac_b));

    always_comb begin
        w_res    = sat_add({{(SAT_W-ACC_W){r_p1_old[ACC_W-1]}}, r_p1_old},
                           {{(SAT_W-PW){r_p1_prod[PW-1]}}, r_p1_prod}, ACC_W);
        w_p2_sum = w_res.sum[ACC_W-1:0];
    end

    // The old value is fetched in P1, so a P2 write to the same address that
    // lands on the same edge has to be bypassed or its product would be lost.
    always_comb begin
        w_old = '0;
        if (r_p1_valid && (r_p1_addr == i_mac_addr)) begin
            w_old = w_p2_sum;
        end else if (int'(i_mac_addr) < OUT_DEPTH) begin
            w_old = r_acc[i_mac_addr];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p1_valid <= 1'b0;
            r_p1_addr  <= '0;
            r_p1_prod  <= '0;
            r_p1_old   <= '0;
        end else begin
            r_p1_valid <= i_mac_valid;
            if (i_mac_valid) begin
                r_p1_addr <= i_mac_addr;
                r_p1_prod <= w_prod;
                r_p1_old  <= w_old;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) r_acc[i] <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < OUT_DEPTH; i++) r_acc[i] <= '0;
        end else if (r_p1_valid && (int'(r_p1_addr) < OUT_DEPTH)) begin
            r_acc[r_p1_addr] <= w_p2_sum;
        end
    end

    assign o_sat     = r_p1_valid && w_res.sat;
    assign o_rd_data = (int'(i_rd_addr) < OUT_DEPTH) ? r_acc[i_rd_addr] : '0;
endmodule

// File: rtl/sparse_pe.sv
// Sparse-convolution PE: intersects compressed IA / weight channel lists, accumulates
// matched products into the output buffer and streams the buffer out on request.
module sparse_pe
    import sparse_pe_pkg::*;
#(
    parameter int IA_DW     = DEF_IA_DW,
    parameter int W_DW      = DEF_W_DW,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int C_W       = DEF_C_W,
    parameter int IA_LEN    = DEF_IA_LEN,
    parameter int W_LEN     = DEF_W_LEN,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH,
    localparam int AW       = addr_w(OUT_DEPTH),
    localparam int IA_LW    = $clog2(IA_LEN) + 1,
    localparam int W_LW     = $clog2(W_LEN) + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_acc_clear,
    input  logic [IA_LEN*IA_DW-1:0] i_ia_data,
    input  logic [IA_LEN*C_W-1:0]   i_ia_c,
    input  logic [IA_LW-1:0]        i_ia_len,
    input  logic [W_LEN*W_DW-1:0]   i_w_data,
    input  logic [W_LEN*C_W-1:0]    i_w_c,
    input  logic [W_LEN*AW-1:0]     i_w_addr,
    input  logic [W_LW-1:0]         i_w_len,
    input  logic                    i_rd_start,
    input  logic                    i_rd_ready,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_sat,
    output logic                    o_rd_valid,
    output logic [ACC_W-1:0]        o_rd_data,
    output logic [AW-1:0]           o_rd_addr,
    output logic                    o_rd_last
);
    localparam int IA_IW = IA_LW - 1;
    localparam int W_IW  = W_LW - 1;

    state_t                  r_state, w_next;
    logic [IA_LEN*IA_DW-1:0] r_ia_data;
    logic [IA_LEN*C_W-1:0]   r_ia_c;
    logic [IA_LW-1:0]        r_ia_len, r_p, w_p_nxt;
    logic [W_LEN*W_DW-1:0]   r_w_data;
    logic [W_LEN*C_W-1:0]    r_w_c;
    logic [W_LEN*AW-1:0]     r_w_addr;
    logic [W_LW-1:0]         r_w_len, r_q, w_q_nxt;
    logic [AW-1:0]           r_rd_ptr;
    logic                    r_drain, r_done, r_sat;
    logic [IA_IW-1:0]        w_pi;
    logic [W_IW-1:0]         w_qi;
    logic [C_W-1:0]          w_ia_c, w_w_c;
    logic [IA_DW-1:0]        w_ia_d;
    logic [W_DW-1:0]         w_w_d;
    logic [AW-1:0]           w_w_a;
    logic                    w_accept, w_clear, w_mac_valid, w_mac_sat, w_rd_fire, w_rd_begin;
    logic [ACC_W-1:0]        w_buf_rd;

    assign w_pi   = r_p[IA_IW-1:0];
    assign w_qi   = r_q[W_IW-1:0];
    assign w_ia_c = r_ia_c[int'(w_pi)*C_W +: C_W];
    assign w_ia_d = r_ia_data[int'(w_pi)*IA_DW +: IA_DW];
    assign w_w_c  = r_w_c[int'(w_qi)*C_W +: C_W];
    assign w_w_d  = r_w_data[int'(w_qi)*W_DW +: W_DW];
    assign w_w_a  = r_w_addr[int'(w_qi)*AW +: AW];

    // Matches advance only q, so repeated weight channels all pair with the same IA entry.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_clear     = 1'b0;
        w_mac_valid = 1'b0;
        w_rd_begin  = 1'b0;
        w_rd_fire   = 1'b0;
        w_p_nxt     = r_p;
        w_q_nxt     = r_q;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    w_clear  = i_acc_clear;
                    w_next   = ST_MATCH;
                end else if (i_rd_start) begin
                    w_rd_begin = 1'b1;
                    w_next     = ST_READ;
                end
            end
            ST_MATCH: begin
                if ((r_p < r_ia_len) && (r_q < r_w_len)) begin
                    if (w_ia_c == w_w_c) begin
                        w_mac_valid = 1'b1;
                        w_q_nxt     = r_q + 1'b1;
                    end else if (w_ia_c < w_w_c) begin
                        w_p_nxt = r_p + 1'b1;
                    end else begin
                        w_q_nxt = r_q + 1'b1;
                    end
                end
                if ((w_p_nxt >= r_ia_len) || (w_q_nxt >= r_w_len)) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_drain) w_next = ST_IDLE;
            end
            ST_READ: begin
                w_rd_fire = i_rd_ready;
                if (i_rd_ready && (int'(r_rd_ptr) == OUT_DEPTH - 1)) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ia_data <= '0;
            r_ia_c    <= '0;
            r_ia_len  <= '0;
            r_w_data  <= '0;
            r_w_c     <= '0;
            r_w_addr  <= '0;
            r_w_len   <= '0;
            r_p       <= '0;
            r_q       <= '0;
            r_rd_ptr  <= '0;
            r_drain   <= 1'b0;
            r_done    <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_done  <= (r_state == ST_DRAIN) && r_drain;
            r_drain <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
            if (w_accept) begin
                r_ia_data <= i_ia_data;
                r_ia_c    <= i_ia_c;
                r_ia_len  <= i_ia_len;
                r_w_data  <= i_w_data;
                r_w_c     <= i_w_c;
                r_w_addr  <= i_w_addr;
                r_w_len   <= i_w_len;
                r_p       <= '0;
                r_q       <= '0;
                r_sat     <= 1'b0;
            end else begin
                if (r_state == ST_MATCH) begin
                    r_p <= w_p_nxt;
                    r_q <= w_q_nxt;
                end
                if (w_mac_sat) r_sat <= 1'b1;
            end
            if (w_rd_begin) begin
                r_rd_ptr <= '0;
            end else if (w_rd_fire) begin
                r_rd_ptr <= (int'(r_rd_ptr) == OUT_DEPTH - 1) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    sparse_pe_acc_buf #(
        .IA_DW    (IA_DW),
        .W_DW     (W_DW),
        .ACC_W    (ACC_W),
        .OUT_DEPTH(OUT_DEPTH),
        .AW       (AW)
    ) u_acc_buf (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_clear),
        .i_mac_valid(w_mac_valid),
        .i_mac_addr (w_w_a),
        .i_mac_a    (w_ia_d),
        .i_mac_b    (w_w_d),
        .i_rd_addr  (r_rd_ptr),
        .o_rd_data  (w_buf_rd),
        .o_sat      (w_mac_sat)
    );

    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;
    assign o_sat      = r_sat;
    assign o_rd_valid = (r_state == ST_READ);
    assign o_rd_data  = o_rd_valid ? w_buf_rd : '0;
    assign o_rd_addr  = r_rd_ptr;
    assign o_rd_last  = o_rd_valid && (int'(r_rd_ptr) == OUT_DEPTH - 1);
endmodule

// File: tb/tb_sparse_pe.sv
// Directed bench for sparse_pe: intersect/MAC, multi-pass accumulation, same-address
// forwarding, saturation, stalled readout and reset abort, against hand-computed values.
module tb_sparse_pe;
    localparam int IA_DW     = 16;
    localparam int W_DW      = 16;
    localparam int ACC_W     = 32;
    localparam int C_W       = 8;
    localparam int IA_LEN    = 32;
    localparam int W_LEN     = 32;
    localparam int OUT_DEPTH = 96;
    localparam int AW        = 7;
    localparam int IA_LW     = 6;
    localparam int W_LW      = 6;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    i_start, i_acc_clear, i_rd_start, i_rd_ready;
    logic [IA_LEN*IA_DW-1:0] i_ia_data;
    logic [IA_LEN*C_W-1:0]   i_ia_c;
    logic [IA_LW-1:0]        i_ia_len;
    logic [W_LEN*W_DW-1:0]   i_w_data;
    logic [W_LEN*C_W-1:0]    i_w_c;
    logic [W_LEN*AW-1:0]     i_w_addr;
    logic [W_LW-1:0]         i_w_len;
    logic                    o_busy, o_done, o_sat, o_rd_valid, o_rd_last;
    logic [ACC_W-1:0]        o_rd_data;
    logic [AW-1:0]           o_rd_addr;

    int               total = 0;
    int               bad   = 0;
    logic [ACC_W-1:0] expAcc [OUT_DEPTH];
    logic [ACC_W-1:0] rdBuf  [OUT_DEPTH];

    always #5 clk = ~clk;

    sparse_pe #(
        .IA_DW(IA_DW), .W_DW(W_DW), .ACC_W(ACC_W), .C_W(C_W),
        .IA_LEN(IA_LEN), .W_LEN(W_LEN), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (i_start),
        .i_acc_clear(i_acc_clear),
        .i_ia_data  (i_ia_data),
        .i_ia_c     (i_ia_c),
        .i_ia_len   (i_ia_len),
        .i_w_data   (i_w_data),
        .i_w_c      (i_w_c),
        .i_w_addr   (i_w_addr),
        .i_w_len    (i_w_len),
        .i_rd_start (i_rd_start),
        .i_rd_ready (i_rd_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_sat      (o_sat),
        .o_rd_valid (o_rd_valid),
        .o_rd_data  (o_rd_data),
        .o_rd_addr  (o_rd_addr),
        .o_rd_last  (o_rd_last)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearJob(input int il, input int wl);
        i_ia_data = '0;
        i_ia_c    = '0;
        i_w_data  = '0;
        i_w_c     = '0;
        i_w_addr  = '0;
        i_ia_len  = IA_LW'(il);
        i_w_len   = W_LW'(wl);
    endtask

    task automatic setIa(input int i, input int c, input int d);
        i_ia_c[i*C_W +: C_W]         = C_W'(c);
        i_ia_data[i*IA_DW +: IA_DW]  = IA_DW'(d);
    endtask

    task automatic setW(input int i, input int c, input int d, input int a);
        i_w_c[i*C_W +: C_W]       = C_W'(c);
        i_w_data[i*W_DW +: W_DW]  = W_DW'(d);
        i_w_addr[i*AW +: AW]      = AW'(a);
    endtask

    task automatic zeroExpected();
        for (int i = 0; i < OUT_DEPTH; i++) expAcc[i] = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".busy"},    o_busy, 0);
        checkOutput({tag, ".done"},    o_done, 0);
        checkOutput({tag, ".sat"},     o_sat, 0);
        checkOutput({tag, ".rdValid"}, o_rd_valid, 0);
        checkOutput({tag, ".rdData"},  o_rd_data, 0);
        checkOutput({tag, ".rdAddr"},  o_rd_addr, 0);
        checkOutput({tag, ".rdLast"},  o_rd_last, 0);
    endtask

    // Start a job; cyc counts the cycle after the accepting edge as 1, so done lands at N+3.
    task automatic applyStimulus(input logic clr, input int expN);
        int cyc;
        @(negedge clk);
        i_start     = 1'b1;
        i_acc_clear = clr;
        @(posedge clk);
        #1;
        i_start     = 1'b0;
        i_acc_clear = 1'b0;
        cyc = 1;
        checkOutput("busyAfterStart", o_busy, 1);
        while (!o_done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("doneLatency", cyc, expN + 3);
        checkOutput("idleAtDone", o_busy, 0);
    endtask

    task automatic readAll(input bit toggle);
        int               idx = 0;
        int               cyc = 0;
        bit               stalled = 1'b0;
        logic [ACC_W-1:0] holdData = '0;
        logic [AW-1:0]    holdAddr = '0;
        @(negedge clk);
        i_rd_start = 1'b1;
        i_rd_ready = 1'b0;
        @(negedge clk);
        i_rd_start = 1'b0;
        checkOutput("rdFirstValid", o_rd_valid, 1);
        checkOutput("donePulseEnded", o_done, 0);
        while (idx < OUT_DEPTH && cyc < 4 * OUT_DEPTH) begin
            i_rd_ready = toggle ? cyc[0] : 1'b1;
            if (stalled) begin
                checkOutput("rdHoldData", o_rd_data, holdData);
                checkOutput("rdHoldAddr", o_rd_addr, holdAddr);
            end
            if (o_rd_valid && i_rd_ready) begin
                checkOutput("rdAddr", o_rd_addr, idx);
                checkOutput("rdLast", o_rd_last, idx == OUT_DEPTH - 1);
                rdBuf[idx] = o_rd_data;
                idx++;
                stalled = 1'b0;
            end else begin
                stalled  = 1'b1;
                holdData = o_rd_data;
                holdAddr = o_rd_addr;
            end
            @(negedge clk);
            cyc++;
        end
        i_rd_ready = 1'b0;
        checkOutput("rdCount", idx, OUT_DEPTH);
        checkOutput("rdCycles", cyc, toggle ? 2 * OUT_DEPTH : OUT_DEPTH);
        checkOutput("rdEndValid", o_rd_valid, 0);
        checkOutput("rdEndBusy", o_busy, 0);
        for (int i = 0; i < OUT_DEPTH; i++) begin
            checkOutput($sformatf("acc[%0d]", i), rdBuf[i], expAcc[i]);
        end
    endtask

    initial begin
        rst         = 1'b1;
        i_start     = 1'b0;
        i_acc_clear = 1'b0;
        i_rd_start  = 1'b0;
        i_rd_ready  = 1'b0;
        clearJob(0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("inReset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("afterReset");

        $display("[TB] basic intersect with clear");
        clearJob(3, 2);
        setIa(0, 1, 2);
        setIa(1, 3, 3);
        setIa(2, 5, 4);
        setW(0, 3, 10, 0);
        setW(1, 5, -2, 1);
        zeroExpected();
        expAcc[0] = 32'd30;
        expAcc[1] = 32'hFFFF_FFF8;
        applyStimulus(1'b1, 4);
        checkOutput("satAfterJob1", o_sat, 0);
        readAll(1'b0);

        $display("[TB] second pass without clear");
        applyStimulus(1'b0, 4);
        expAcc[0] = 32'd60;
        expAcc[1] = 32'hFFFF_FFF0;
        readAll(1'b0);

        $display("[TB] back-to-back same-address MACs");
        clearJob(1, 2);
        setIa(0, 2, 7);
        setW(0, 2, 3, 5);
        setW(1, 2, 4, 5);
        zeroExpected();
        expAcc[5] = 32'd49;
        applyStimulus(1'b1, 2);
        readAll(1'b0);

        $display("[TB] saturation");
        clearJob(1, 3);
        setIa(0, 0, 16'h7FFF);
        setW(0, 0, 16'h7FFF, 7);
        setW(1, 0, 16'h7FFF, 7);
        setW(2, 0, 16'h7FFF, 7);
        zeroExpected();
        expAcc[7] = 32'h7FFF_FFFF;
        applyStimulus(1'b1, 3);
        checkOutput("satSticky", o_sat, 1);

        $display("[TB] zero-length job, stalled readout");
        i_ia_len = '0;
        applyStimulus(1'b0, 1);
        checkOutput("satClearedByStart", o_sat, 0);
        readAll(1'b1);

        $display("[TB] reset during MATCH");
        clearJob(3, 2);
        setIa(0, 1, 2);
        setIa(1, 3, 3);
        setIa(2, 5, 4);
        setW(0, 3, 10, 0);
        setW(1, 5, -2, 1);
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetOutputs("midJobReset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("noDoneAfterAbort", o_done, 0);
        end
        zeroExpected();
        readAll(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
